mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single unified instruction/data memory of the multicycle core.
- Requester 0: the CPU.
- Requester 1: the program loader/DMA engine.
Serialises one transaction at a time onto a synchronous memory with fixed read latency. Returns completion pulses and registered read data to the winner.

---
 rtl/lib_cpu.sv | 16 +
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_cpu.sv
// Shared types for the multicycle core: memory arbiter FSM states and requester ids.
package lib_cpu;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } ARB_STATE;

    typedef enum logic {
        CPU    = 1'b0,
        LOADER = 1'b1
    } REQ_ID;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin on ties, or fixed CPU priority when prio_mode is set.
module rr_pick2
    import lib_cpu::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output REQ_ID      winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = CPU;
        if (req == 2'b11) begin
            winner = prio_mode ? CPU : REQ_ID'(~last);
        end else if (req[1]) begin
            winner = LOADER;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader transactions onto a fixed-latency synchronous memory.
// Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module mem_arbiter
    import lib_cpu::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be >= 1");
    end

    localparam int unsigned      CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0]  CntLoad = CntW'(MEM_LAT - 1);

`ifdef MEM_ARB_CPU_PRIO_EN
    localparam logic PrioMode = 1'b1;
`else
    localparam logic PrioMode = 1'b0;
`endif

    ARB_STATE          state_q, state_d;
    REQ_ID             win_q, win_d;
    logic              we_q, we_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    REQ_ID pick_win;
    logic  pick_any;

    rr_pick2 u_pick (
        .req       ({req1, req0}),
        .last      (rr_last_q),
        .prio_mode (PrioMode),
        .winner    (pick_win),
        .any       (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    win_d       = pick_win;
                    we_d        = (pick_win == LOADER) ? we1 : we0;
                    mem_addr_d  = (pick_win == LOADER) ? addr1 : addr0;
                    mem_wdata_d = (pick_win == LOADER) ? wdata1 : wdata0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CntLoad;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (win_q == LOADER) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
`ifndef MEM_ARB_CPU_PRIO_EN
                rr_last_d = win_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            win_q       <= CPU;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rr_last_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Grants span ISSUE..DONE; strobes and done are pure decodes of the registered state.
    always_comb begin
        gnt0      = (state_q != IDLE) && (win_q == CPU);
        gnt1      = (state_q != IDLE) && (win_q == LOADER);
        done0     = (state_q == DONE) && (win_q == CPU);
        done1     = (state_q == DONE) && (win_q == LOADER);
        mem_re    = (state_q == ISSUE) && !we_q;
        mem_we    = (state_q == ISSUE) && we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_arbiter;

    logic clk;
    logic reset_n;

    logic        a_req0, a_we0, a_gnt0, a_done0;
    logic [31:0] a_addr0, a_wdata0, a_rdata0;
    logic        a_req1, a_we1, a_gnt1, a_done1;
    logic [31:0] a_addr1, a_wdata1, a_rdata1;
    logic        a_mem_re, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_req0, b_we0, b_gnt0, b_done0;
    logic [31:0] b_addr0, b_wdata0, b_rdata0;
    logic        b_req1, b_we1, b_gnt1, b_done1;
    logic [31:0] b_addr1, b_wdata1, b_rdata1;
    logic        b_mem_re, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks;
    int errors;
    logic exp_w;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (a_req0),
        .we0       (a_we0),
        .addr0     (a_addr0),
        .wdata0    (a_wdata0),
        .gnt0      (a_gnt0),
        .done0     (a_done0),
        .rdata0    (a_rdata0),
        .req1      (a_req1),
        .we1       (a_we1),
        .addr1     (a_addr1),
        .wdata1    (a_wdata1),
        .gnt1      (a_gnt1),
        .done1     (a_done1),
        .rdata1    (a_rdata1),
        .mem_re    (a_mem_re),
        .mem_we    (a_mem_we),
        .mem_addr  (a_mem_addr),
        .mem_wdata (a_mem_wdata),
        .mem_rdata (a_mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (b_req0),
        .we0       (b_we0),
        .addr0     (b_addr0),
        .wdata0    (b_wdata0),
        .gnt0      (b_gnt0),
        .done0     (b_done0),
        .rdata0    (b_rdata0),
        .req1      (b_req1),
        .we1       (b_we1),
        .addr1     (b_addr1),
        .wdata1    (b_wdata1),
        .gnt1      (b_gnt1),
        .done1     (b_done1),
        .rdata1    (b_rdata1),
        .mem_re    (b_mem_re),
        .mem_we    (b_mem_we),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_rdata (b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        a_req0 = 1'b0; a_we0 = 1'b0; a_addr0 = '0; a_wdata0 = '0;
        a_req1 = 1'b0; a_we1 = 1'b0; a_addr1 = '0; a_wdata1 = '0;
        a_mem_rdata = 32'hDEADBEEF;
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = '0; b_wdata1 = '0;
        b_mem_rdata = 32'h0BADF00D;

        // Reset state
        tick();
        tick();
        chk1("rst_gnt0", a_gnt0, 1'b0);
        chk1("rst_gnt1", a_gnt1, 1'b0);
        chk1("rst_done0", a_done0, 1'b0);
        chk1("rst_done1", a_done1, 1'b0);
        chk1("rst_mem_re", a_mem_re, 1'b0);
        chk1("rst_mem_we", a_mem_we, 1'b0);
        chk32("rst_rdata0", a_rdata0, 32'h0);
        chk32("rst_rdata1", a_rdata1, 32'h0);
        chk32("rst_mem_addr", a_mem_addr, 32'h0);
        chk32("rst_mem_wdata", a_mem_wdata, 32'h0);
        reset_n = 1'b1;

        // CPU read, MEM_LAT=1: done in cycle 3
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h10;
        tick();
        chk1("rd_c1_mem_re", a_mem_re, 1'b1);
        chk1("rd_c1_mem_we", a_mem_we, 1'b0);
        chk32("rd_c1_mem_addr", a_mem_addr, 32'h10);
        chk1("rd_c1_gnt0", a_gnt0, 1'b1);
        chk1("rd_c1_done0", a_done0, 1'b0);
        a_req0 = 1'b0;
        tick();
        chk1("rd_c2_gnt0", a_gnt0, 1'b1);
        chk1("rd_c2_mem_re", a_mem_re, 1'b0);
        chk1("rd_c2_done0", a_done0, 1'b0);
        tick();
        chk1("rd_c3_done0", a_done0, 1'b1);
        chk1("rd_c3_gnt0", a_gnt0, 1'b1);
        chk1("rd_c3_gnt1", a_gnt1, 1'b0);
        chk32("rd_c3_rdata0", a_rdata0, 32'hDEADBEEF);
        tick();
        chk1("rd_c4_gnt0", a_gnt0, 1'b0);
        chk1("rd_c4_done0", a_done0, 1'b0);
        chk32("rd_c4_rdata0", a_rdata0, 32'hDEADBEEF);

        // Loader write: done in cycle 2, rdata1 untouched
        a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h40; a_wdata1 = 32'h12345678;
        tick();
        chk1("wr_c1_mem_we", a_mem_we, 1'b1);
        chk1("wr_c1_mem_re", a_mem_re, 1'b0);
        chk32("wr_c1_mem_addr", a_mem_addr, 32'h40);
        chk32("wr_c1_mem_wdata", a_mem_wdata, 32'h12345678);
        chk1("wr_c1_gnt1", a_gnt1, 1'b1);
        chk1("wr_c1_gnt0", a_gnt0, 1'b0);
        a_req1 = 1'b0;
        tick();
        chk1("wr_c2_done1", a_done1, 1'b1);
        chk1("wr_c2_done0", a_done0, 1'b0);
        chk1("wr_c2_mem_we", a_mem_we, 1'b0);
        chk32("wr_c2_rdata1", a_rdata1, 32'h0);
        tick();
        chk1("wr_c3_gnt1", a_gnt1, 1'b0);

        // Continuous contention, four writes
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 32'h100; a_wdata0 = 32'hAAAA0000;
        a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h200; a_wdata1 = 32'hBBBB0000;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_CPU_PRIO_EN
            exp_w = 1'b0;
`else
            exp_w = (k % 2 == 1);
`endif
            tick();
            chk1("cont_gnt0", a_gnt0, !exp_w);
            chk1("cont_gnt1", a_gnt1, exp_w);
            chk32("cont_mem_addr", a_mem_addr, exp_w ? 32'h200 : 32'h100);
            tick();
            chk1("cont_done0", a_done0, !exp_w);
            chk1("cont_done1", a_done1, exp_w);
            if (k == 3) begin
                a_req0 = 1'b0;
                a_req1 = 1'b0;
            end
            tick();
            chk1("cont_idle_gnt", a_gnt0 | a_gnt1, 1'b0);
        end

        // CPU keeps req high through done with a new address
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 32'h18; a_wdata0 = 32'hA5A5A5A5;
        tick();
        chk32("b2b_c1_mem_addr", a_mem_addr, 32'h18);
        tick();
        chk1("b2b_c2_done0", a_done0, 1'b1);
        a_addr0 = 32'h20; a_wdata0 = 32'h5A5A5A5A;
        tick();
        chk1("b2b_idle_gnt0", a_gnt0, 1'b0);
        chk32("b2b_idle_mem_addr_hold", a_mem_addr, 32'h18);
        tick();
        chk1("b2b_c4_gnt0", a_gnt0, 1'b1);
        chk1("b2b_c4_mem_we", a_mem_we, 1'b1);
        chk32("b2b_c4_mem_addr", a_mem_addr, 32'h20);
        chk32("b2b_c4_mem_wdata", a_mem_wdata, 32'h5A5A5A5A);
        a_req0 = 1'b0;
        tick();
        chk1("b2b_c5_done0", a_done0, 1'b1);
        tick();

        // Reset during WAIT of a CPU read
        a_mem_rdata = 32'h11111111;
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h30;
        tick();
        chk1("rstw_c1_mem_re", a_mem_re, 1'b1);
        a_req0 = 1'b0;
        tick();
        chk1("rstw_c2_gnt0", a_gnt0, 1'b1);
        reset_n = 1'b0;
        tick();
        chk1("rstw_done0", a_done0, 1'b0);
        chk1("rstw_done1", a_done1, 1'b0);
        chk1("rstw_mem_re", a_mem_re, 1'b0);
        chk1("rstw_gnt0", a_gnt0, 1'b0);
        chk32("rstw_rdata0", a_rdata0, 32'h0);
        reset_n = 1'b1;
        tick();
        chk1("rstw_after_done0", a_done0, 1'b0);
        chk1("rstw_after_done1", a_done1, 1'b0);
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 32'h50;
        a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h60;
        tick();
        chk1("rstw_tie_gnt0", a_gnt0, 1'b1);
        chk1("rstw_tie_gnt1", a_gnt1, 1'b0);
        a_req0 = 1'b0; a_req1 = 1'b0;
        tick();
        chk1("rstw_tie_done0", a_done0, 1'b1);
        tick();

        // MEM_LAT=3 read on instance b: done in cycle 5
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 32'h44;
        tick();
        chk1("lat3_c1_mem_re", b_mem_re, 1'b1);
        chk32("lat3_c1_mem_addr", b_mem_addr, 32'h44);
        b_req0 = 1'b0;
        tick();
        chk1("lat3_c2_mem_re", b_mem_re, 1'b0);
        chk1("lat3_c2_done0", b_done0, 1'b0);
        tick();
        chk1("lat3_c3_mem_re", b_mem_re, 1'b0);
        chk1("lat3_c3_done0", b_done0, 1'b0);
        tick();
        chk1("lat3_c4_done0", b_done0, 1'b0);
        chk1("lat3_c4_gnt0", b_gnt0, 1'b1);
        chk32("lat3_c4_rdata0", b_rdata0, 32'h0);
        tick();
        chk1("lat3_c5_done0", b_done0, 1'b1);
        chk32("lat3_c5_rdata0", b_rdata0, 32'h0BADF00D);
        chk32("lat3_c5_rdata1", b_rdata1, 32'h0);
        tick();
        chk1("lat3_c6_done0", b_done0, 1'b0);
        chk1("lat3_c6_gnt0", b_gnt0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
